// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: Moore control word per state, plus a
// retired-instruction counter and a sticky illegal-opcode error flag.
module mips_multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter bit ERR_HALT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  output logic             o_pcWrite,
  output logic             o_pcWriteCond,
  output logic [1:0]       o_pcSrc,
  output logic             o_iorD,
  output logic             o_memWrite,
  output logic             o_irWrite,
  output logic             o_regWrite,
  output logic [1:0]       o_regDst,
  output logic [1:0]       o_memToReg,
  output logic             o_aluSrcA,
  output logic [1:0]       o_aluSrcB,
  output logic [1:0]       o_aluOp,
  output logic [3:0]       o_state,
  output logic             o_retired,
  output logic [CNT_W-1:0] o_instrCount,
  output logic             o_error
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,
    S_ITEXEC = 4'd8,  S_ITWB   = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13, S_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08, FN_ADD  = 6'h20, FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instrCount;
  logic             r_error;
  logic             w_illegal;
  logic             w_retired;
  logic             w_pcWrite, w_pcWriteCond, w_memWrite, w_irWrite, w_regWrite;

  always_comb begin
    w_next        = S_FETCH;
    w_illegal     = 1'b0;
    w_retired     = 1'b0;
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_regWrite    = 1'b0;
    o_pcSrc       = 2'd0;
    o_iorD        = 1'b0;
    o_regDst      = 2'd0;
    o_memToReg    = 2'd0;
    o_aluSrcA     = 1'b0;
    o_aluSrcB     = 2'd0;
    o_aluOp       = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_irWrite = 1'b1;
        w_pcWrite = 1'b1;
        o_aluSrcB = 2'd1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched
        o_aluSrcB = 2'd3;
        case (i_opcode)
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_RTYPE: begin
            if (i_funct == FN_ADD || i_funct == FN_SUB || i_funct == FN_SLT)
              w_next = S_RTEXEC;
            else if (i_funct == FN_JR)
              w_next = S_JR;
            else
              w_illegal = 1'b1;
          end
          OP_ADDI, OP_XORI: w_next = S_ITEXEC;
          OP_BNE:           w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_JAL:           w_next = S_JAL;
          default:          w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
          w_next    = ERR_HALT ? S_ERROR : S_FETCH;
          w_retired = !ERR_HALT;
        end
      end
      S_MEMADR: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'd2;
        w_next    = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        o_iorD = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regWrite = 1'b1;
        o_memToReg = 2'd1;
        w_retired  = 1'b1;
      end
      S_MEMWR: begin
        o_iorD     = 1'b1;
        w_memWrite = 1'b1;
        w_retired  = 1'b1;
      end
      S_RTEXEC: begin
        o_aluSrcA = 1'b1;
        if (i_funct == FN_SUB)      o_aluOp = 2'd1;
        else if (i_funct == FN_SLT) o_aluOp = 2'd3;
        w_next = S_RTWB;
      end
      S_RTWB: begin
        w_regWrite = 1'b1;
        o_regDst   = 2'd1;
        w_retired  = 1'b1;
      end
      S_ITEXEC: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'd2;
        o_aluOp   = (i_opcode == OP_XORI) ? 2'd2 : 2'd0;
        w_next    = S_ITWB;
      end
      S_ITWB: begin
        w_regWrite = 1'b1;
        w_retired  = 1'b1;
      end
      S_BRANCH: begin
        o_aluSrcA     = 1'b1;
        o_aluOp       = 2'd1;
        o_pcSrc       = 2'd1;
        w_pcWriteCond = ~i_zero;
        w_retired     = 1'b1;
      end
      S_JUMP: begin
        w_pcWrite = 1'b1;
        o_pcSrc   = 2'd2;
        w_retired = 1'b1;
      end
      S_JAL: begin
        w_pcWrite  = 1'b1;
        o_pcSrc    = 2'd2;
        w_regWrite = 1'b1;
        o_regDst   = 2'd2;
        o_memToReg = 2'd2;
        w_retired  = 1'b1;
      end
      S_JR: begin
        w_pcWrite = 1'b1;
        o_pcSrc   = 2'd3;
        w_retired = 1'b1;
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks every side-effecting strobe so nothing is written mid-reset
  assign o_pcWrite     = w_pcWrite     & ~i_reset;
  assign o_pcWriteCond = w_pcWriteCond & ~i_reset;
  assign o_memWrite    = w_memWrite    & ~i_reset;
  assign o_irWrite     = w_irWrite     & ~i_reset;
  assign o_regWrite    = w_regWrite    & ~i_reset;
  assign o_retired     = w_retired     & ~i_reset;
  assign o_state       = r_state;
  assign o_instrCount  = r_instrCount;
  assign o_error       = r_error;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_instrCount <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retired) r_instrCount <= r_instrCount + CNT_W'(1);
      if (w_next == S_ERROR) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: two instances (halting and NOP-on-illegal)
// checked every cycle against a per-instruction state-path model.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;

  logic       pcWH, pcWCH, iorDH, memWH, irWH, regWH, srcAH, retH, errH;
  logic [1:0] pcSrcH, regDstH, m2rH, srcBH, aluOpH;
  logic [3:0] stH;
  logic [31:0] cntH;
  logic       pcWN, pcWCN, iorDN, memWN, irWN, regWN, srcAN, retN, errN;
  logic [1:0] pcSrcN, regDstN, m2rN, srcBN, aluOpN;
  logic [3:0] stN;
  logic [3:0] cntN;

  mips_multicycle_ctrl #(.CNT_W(32), .ERR_HALT(1'b1)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .o_pcWrite(pcWH), .o_pcWriteCond(pcWCH), .o_pcSrc(pcSrcH), .o_iorD(iorDH),
    .o_memWrite(memWH), .o_irWrite(irWH), .o_regWrite(regWH), .o_regDst(regDstH),
    .o_memToReg(m2rH), .o_aluSrcA(srcAH), .o_aluSrcB(srcBH), .o_aluOp(aluOpH),
    .o_state(stH), .o_retired(retH), .o_instrCount(cntH), .o_error(errH));

  mips_multicycle_ctrl #(.CNT_W(4), .ERR_HALT(1'b0)) dutNop (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .o_pcWrite(pcWN), .o_pcWriteCond(pcWCN), .o_pcSrc(pcSrcN), .o_iorD(iorDN),
    .o_memWrite(memWN), .o_irWrite(irWN), .o_regWrite(regWN), .o_regDst(regDstN),
    .o_memToReg(m2rN), .o_aluSrcA(srcAN), .o_aluSrcB(srcBN), .o_aluOp(aluOpN),
    .o_state(stN), .o_retired(retN), .o_instrCount(cntN), .o_error(errN));

  wire [16:0] ctlH = {pcWH, pcWCH, pcSrcH, iorDH, memWH, irWH, regWH, regDstH, m2rH, srcAH, srcBH, aluOpH};
  wire [16:0] ctlN = {pcWN, pcWCN, pcSrcN, iorDN, memWN, irWN, regWN, regDstN, m2rN, srcAN, srcBN, aluOpN};

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction classes: 0 LW, 1 SW, 2 R-ALU, 3 JR, 4 I-ALU, 5 BNE, 6 J, 7 JAL, 8 illegal
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return 0;
      6'h2B: return 1;
      6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) ? 2 : (fn == 6'h08) ? 3 : 8;
      6'h08, 6'h0E: return 4;
      6'h05: return 5;
      6'h02: return 6;
      6'h03: return 7;
      default: return 8;
    endcase
  endfunction

  function automatic int pathLen(input int cls, input bit halt);
    case (cls)
      0: return 5;
      1, 2, 4: return 4;
      5, 6, 7, 3: return 3;
      default: return halt ? 3 : 2;
    endcase
  endfunction

  function automatic int pathAt(input int cls, input int idx);
    int third[9];
    int fourth[9];
    third  = '{2, 2, 6, 13, 8, 10, 11, 12, 15};
    fourth = '{3, 5, 7, 0, 9, 0, 0, 0, 0};
    case (idx)
      0: return 0;
      1: return 1;
      2: return third[cls];
      3: return fourth[cls];
      default: return 4;
    endcase
  endfunction

  function automatic logic [16:0] expCtrl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                          input logic z, input logic rst);
    logic pw, pwc, iord, mw, irw, rw, sa;
    logic [1:0] ps, rd, m2r, sb, ao;
    {pw, pwc, iord, mw, irw, rw, sa} = '0;
    {ps, rd, m2r, sb, ao} = '0;
    case (st)
      0:  begin pw = 1; irw = 1; sb = 1; end
      1:  sb = 3;
      2:  begin sa = 1; sb = 2; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; ao = (fn == 6'h22) ? 2'd1 : (fn == 6'h2A) ? 2'd3 : 2'd0; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; sb = 2; ao = (op == 6'h0E) ? 2'd2 : 2'd0; end
      9:  rw = 1;
      10: begin sa = 1; ao = 1; ps = 1; pwc = !z; end
      11: begin pw = 1; ps = 2; end
      12: begin pw = 1; ps = 2; rw = 1; rd = 2; m2r = 2; end
      13: begin pw = 1; ps = 3; end
      default: ;
    endcase
    if (rst) {pw, pwc, mw, irw, rw} = '0;
    return {pw, pwc, ps, iord, mw, irw, rw, rd, m2r, sa, sb, ao};
  endfunction

  // Model: index 0 mirrors the halting instance, index 1 the NOP instance
  int     mState[2], mPos[2];
  longint mCount[2];
  bit     mError[2];
  bit     mValid = 1'b0;
  int     mCntW[2] = '{32, 4};

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        mState[m] = 0; mPos[m] = 0; mCount[m] = 0; mError[m] = 0; mValid = 1'b1;
      end else if (mValid && mState[m] != 15) begin
        int cls, len;
        cls = classify(opcode, funct);
        len = pathLen(cls, m == 0);
        if (mPos[m] == len - 1) begin
          mCount[m] = (mCount[m] + 1) & ((64'd1 << mCntW[m]) - 1);
          mPos[m] = 0;
          mState[m] = 0;
        end else begin
          mPos[m]++;
          mState[m] = pathAt(cls, mPos[m]);
          if (mState[m] == 15) mError[m] = 1'b1;
        end
      end
    end
  end

  task automatic checkDut(input int m, input logic [3:0] st, input logic [16:0] ctl,
                          input logic ret, input longint cnt, input logic err);
    int len;
    bit expRet;
    len = pathLen(classify(opcode, funct), m == 0);
    expRet = !reset && mState[m] != 15 && mPos[m] == len - 1;
    checkOutput($sformatf("state%0d", m), st, mState[m]);
    checkOutput($sformatf("ctrl%0d", m), ctl, expCtrl(mState[m], opcode, funct, zero, reset));
    checkOutput($sformatf("retired%0d", m), ret, expRet);
    checkOutput($sformatf("count%0d", m), cnt, mCount[m]);
    checkOutput($sformatf("error%0d", m), err, mError[m]);
  endtask

  always @(negedge clk) begin
    if (mValid) begin
      checkDut(0, stH, ctlH, retH, longint'(cntH), errH);
      checkDut(1, stN, ctlN, retN, longint'(cntN), errN);
    end
  end

  logic [16:0] seen[16];

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int expLat, input string name);
    int lat = 0;
    opcode = op; funct = fn; zero = z;
    do begin
      @(posedge clk); #2;
      lat++;
      seen[stH] = ctlH;
    end while (stH !== 4'd0 && lat < 10);
    checkOutput({name, "Latency"}, lat, expLat);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetStrobes", {pcWH, pcWCH, memWH, irWH, regWH, retH}, 0);
    checkOutput("resetState", stH, 0);
    reset = 1'b0;

    applyStimulus(6'h23, 6'h00, 1'b0, 5, "lw");
    checkOutput("lwMemWb", seen[4], 17'b0_0_00_0_0_0_1_00_01_0_00_00);
    checkOutput("lwCount", cntH, 1);
    applyStimulus(6'h2B, 6'h00, 1'b0, 4, "sw");
    applyStimulus(6'h00, 6'h20, 1'b0, 4, "add");
    checkOutput("addAluOp", seen[6][1:0], 0);
    applyStimulus(6'h00, 6'h22, 1'b0, 4, "sub");
    checkOutput("subAluOp", seen[6][1:0], 1);
    applyStimulus(6'h00, 6'h2A, 1'b0, 4, "slt");
    checkOutput("sltAluOp", seen[6][1:0], 3);
    applyStimulus(6'h00, 6'h08, 1'b0, 3, "jr");
    checkOutput("jrCtrl", seen[13], 17'b1_0_11_0_0_0_0_00_00_0_00_00);
    applyStimulus(6'h08, 6'h00, 1'b0, 4, "addi");
    applyStimulus(6'h0E, 6'h00, 1'b0, 4, "xori");
    checkOutput("xoriAluOp", seen[8][1:0], 2);
    applyStimulus(6'h05, 6'h00, 1'b1, 3, "bneTaken0");
    checkOutput("bneZero1", seen[10], 17'b0_0_01_0_0_0_0_00_00_1_00_01);
    applyStimulus(6'h05, 6'h00, 1'b0, 3, "bneTaken1");
    checkOutput("bneZero0", seen[10], 17'b0_1_01_0_0_0_0_00_00_1_00_01);
    applyStimulus(6'h02, 6'h00, 1'b0, 3, "j");
    applyStimulus(6'h03, 6'h00, 1'b0, 3, "jal");
    checkOutput("jalCtrl", seen[12], 17'b1_0_10_0_0_0_1_10_10_0_00_00);
    checkOutput("count12", cntH, 12);

    // Illegal opcode: halting instance locks up, NOP instance keeps retiring and wraps
    opcode = 6'h3F; funct = 6'h00;
    repeat (40) @(posedge clk);
    #2;
    checkOutput("errState", stH, 15);
    checkOutput("errFlag", errH, 1);
    checkOutput("errStrobes", ctlH, 0);
    checkOutput("nopErrFlag", errN, 0);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    checkOutput("errResetState", stH, 0);
    checkOutput("errResetFlag", errH, 0);
    applyStimulus(6'h08, 6'h00, 1'b0, 4, "addiAfterReset");
    checkOutput("countAfterReset", cntH, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control FSM that sequences a multicycle version of the MIPS-subset datapath. It replaces the single-cycle decoder with one unified instruction/data memory, one ALU and explicit IR/A/B/ALUOut/MDR registers. Each cycle it emits the Moore control word for the current state; only the branch PC-write also depends on the ALU zero flag. It also keeps a retired-instruction counter and a sticky illegal-opcode error for the CPU testbenches.

Parameters:
CNT_W, 32, width of retired-instruction counter
ERR_HALT, 1, 1 = illegal opcode enters sticky ERROR; 0 = treat as NOP (return to FETCH)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; forces FETCH and zeroes counter/error
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
pcWrite  out  1  unconditional PC load
pcWriteCond  out  1  BNE-qualified PC load (already ANDed with ~zero)
pcSrc  out  2  0 ALU result, 1 ALUOut (branch target), 2 jump target {PC[31:28],IR[25:0],2'b0}, 3 register A (jr)
iorD  out  1  memory address: 0 PC, 1 ALUOut
memWrite  out  1  memory write strobe
irWrite  out  1  IR load
regWrite  out  1  register file write
regDst  out  2  0 rt, 1 rd, 2 r31
memToReg  out  2  0 ALUOut, 1 MDR, 2 PC (already PC+4)
aluSrcA  out  1  0 PC, 1 A
aluSrcB  out  2  0 B, 1 const 4, 2 sext(imm), 3 sext(imm)<<2
aluOp  out  2  0 ADD, 1 SUB, 2 XOR, 3 SLT
state  out  4  current state encoding (debug)
retired  out  1  one-cycle pulse in each instruction's final state
instrCount  out  CNT_W  count of retired instructions
error  out  1  sticky illegal-opcode flag

Behaviour:
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, ITEXEC 8, ITWB 9, BRANCH 10, JUMP 11, JAL 12, JR 13, ERROR 15. Codes 14 and unlisted values go to FETCH.
- FETCH: iorD=0, irWrite=1, aluSrcA=0, aluSrcB=1, aluOp=ADD, pcSrc=0, pcWrite=1. Always goes to DECODE.
- DECODE: aluSrcA=0, aluSrcB=3, aluOp=ADD, which computes the branch target into ALUOut. Dispatch:
  - LW 0x23 and SW 0x2B -> MEMADR
  - R-type 0x00 with funct ADD 0x20, SUB 0x22 or SLT 0x2A -> RTEXEC
  - R-type 0x00 with funct JR 0x08 -> JR
  - ADDI 0x08 and XORI 0x0E -> ITEXEC
  - BNE 0x05 -> BRANCH
  - J 0x02 -> JUMP
  - JAL 0x03 -> JAL
  - anything else -> ERROR if ERROR_HALT=1, else FETCH.
- MEMADR: aluSrcA=1, aluSrcB=2, ADD. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: iorD=1. Goes to MEMWB.
- MEMWB: regWrite, regDst=0, memToReg=1. Goes to FETCH.
- MEMWR: iorD=1, memWrite. Goes to FETCH.
- RTEXEC: aluSrcA=1, aluSrcB=0, aluOp from funct. Goes to RTWB.
- RTWB: regWrite, regDst=1, memToReg=0. Goes to FETCH.
- ITEXEC: aluSrcA=1, aluSrcB=2, aluOp ADD (ADDI) or XOR (XORI). Goes to ITWB.
- ITWB: regWrite, regDst=0, memToReg=0. Goes to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=0, SUB, pcSrc=1, pcWriteCond=~zero. Goes to FETCH.
- JUMP: pcWrite, pcSrc=2. JAL: same as JUMP plus regWrite, regDst=2, memToReg=2. JR: pcWrite, pcSrc=3. All three go to FETCH.
- ERROR: all strobes 0, error=1. Remains in ERROR until reset.
- Unlisted outputs are 0 in every state.
- Latency in cycles: LW 5; SW, R-type, ADDI, XORI 4; BNE, J, JAL, JR 3.
- retired is high in MEMWB, MEMWR, RTWB, ITWB, BRANCH, JUMP, JAL, JR and in FETCH-bound DECODE (ERROR_HALT=0 NOP case). instrCount increments on the same edge and wraps at 2^CNT_W-1 -> 0.
- Reset: state=FETCH, instrCount=0, error=0 on the next edge; takes priority mid-instruction and from ERROR. While reset=1, all write strobes (pcWrite, pcWriteCond, memWrite, irWrite, regWrite) and retired are forced to 0.

Test Plan:
- Reset held 3 cycles, then released -> state goes 0,1 in successive cycles; instrCount=0; error=0; no write strobe is high during reset.
- LW (opcode 0x23) -> states 0,1,2,3,4; regWrite=1 with memToReg=1 only in state 4; retired pulses once; instrCount=1.
- R-type ADD, SUB, SLT, then JR (funct 0x20, 0x22, 0x2A, 0x08) -> aluOp 0, 1, 3 in RTEXEC; JR takes 3 cycles with pcSrc=3 and pcWrite=1.
- BNE with zero=1, then with zero=0 -> pcWriteCond=0 and 1 respectively in state 10; both take 3 cycles.
- JAL (0x03) -> state 12 has pcWrite=1, regWrite=1, regDst=2, memToReg=2, pcSrc=2.
- Opcode 0x3F with ERROR_HALT=1 -> ERROR with error=1 held for 10+ cycles, strobes 0; reset -> FETCH, error=0. Same opcode with ERROR_HALT=0 -> returns to FETCH after DECODE.
